// File: rtl/branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_hazard_ctrl
// Purpose  : ID-stage branch hazard stall sequencing, comparator forwarding,
//            taken-branch flush and saturating branch statistics.
// Revision : 1.0
// ============================================================================
module branch_hazard_ctrl #(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inBranch,
    input  logic [REG_W-1:0] inRsID,
    input  logic [REG_W-1:0] inRtID,
    input  logic             inRegWriteEX,
    input  logic             inMemReadEX,
    input  logic [REG_W-1:0] inRdEX,
    input  logic             inRegWriteMEM,
    input  logic             inMemReadMEM,
    input  logic [REG_W-1:0] inRdMEM,
    input  logic             inRegWriteWB,
    input  logic [REG_W-1:0] inRdWB,
    input  logic             inPCSrc,
    output logic             outStall,
    output logic             outBubble,
    output logic             outFlush,
    output logic [1:0]       outForwardA,
    output logic [1:0]       outForwardB,
    output logic [CNT_W-1:0] outBranchCnt,
    output logic [CNT_W-1:0] outTakenCnt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             rem_q, rem_d;
    logic [CNT_W-1:0] branch_q, branch_d;
    logic [CNT_W-1:0] taken_q, taken_d;

    logic w_ex_match, w_mem_match;
    logic w_need2, w_need1;
    logic w_stall, w_flush, w_resolve;

    assign w_ex_match  = (inRdEX  != '0) && ((inRdEX  == inRsID) || (inRdEX  == inRtID));
    assign w_mem_match = (inRdMEM != '0) && ((inRdMEM == inRsID) || (inRdMEM == inRtID));

    // A load in EX needs two cycles before its data reaches MEM/WB forwarding.
    assign w_need2 = inRegWriteEX & inMemReadEX & w_ex_match;
    assign w_need1 = (inRegWriteEX & ~inMemReadEX & w_ex_match)
                   | (inRegWriteMEM & inMemReadMEM & w_mem_match);

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        w_stall   = 1'b0;
        w_flush   = 1'b0;
        w_resolve = 1'b0;
        case (state_q)
            IDLE: begin
                if (inBranch) begin
                    if (w_need2) begin
                        w_stall = 1'b1;
                        state_d = STALL;
                        rem_d   = 1'b1;
                    end else if (w_need1) begin
                        w_stall = 1'b1;
                    end else begin
                        w_resolve = 1'b1;
                        w_flush   = inPCSrc;
                    end
                end
            end
            STALL: begin
                w_stall = 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rem_d   = 1'b0;
            end
        endcase
    end

    assign outStall  = w_stall & ~reset;
    assign outBubble = w_stall & ~reset;
    assign outFlush  = w_flush & ~reset;

    always_comb begin
        branch_d = branch_q;
        taken_d  = taken_q;
        if (w_resolve) begin
            if (branch_q != '1)
                branch_d = branch_q + 1'b1;
            if (inPCSrc && (taken_q != '1))
                taken_d = taken_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rem_q    <= 1'b0;
            branch_q <= '0;
            taken_q  <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            branch_q <= branch_d;
            taken_q  <= taken_d;
        end
    end

    assign outBranchCnt = branch_q;
    assign outTakenCnt  = taken_q;

    // MEM/WB forwarding only; a load in MEM is covered by the stall instead.
    always_comb begin
        outForwardA = 2'b00;
        outForwardB = 2'b00;
        if (inRegWriteMEM && !inMemReadMEM && (inRdMEM != '0) && (inRdMEM == inRsID))
            outForwardA = 2'b01;
        else if (inRegWriteWB && (inRdWB != '0) && (inRdWB == inRsID))
            outForwardA = 2'b10;
        if (inRegWriteMEM && !inMemReadMEM && (inRdMEM != '0) && (inRdMEM == inRtID))
            outForwardB = 2'b01;
        else if (inRegWriteWB && (inRdWB != '0) && (inRdWB == inRtID))
            outForwardB = 2'b10;
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_hazard_ctrl
// Purpose  : Directed self-checking bench for branch_hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_branch_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        inBranch;
    logic [4:0]  inRsID, inRtID;
    logic        inRegWriteEX, inMemReadEX;
    logic [4:0]  inRdEX;
    logic        inRegWriteMEM, inMemReadMEM;
    logic [4:0]  inRdMEM;
    logic        inRegWriteWB;
    logic [4:0]  inRdWB;
    logic        inPCSrc;
    logic        outStall, outBubble, outFlush;
    logic [1:0]  outForwardA, outForwardB;
    logic [15:0] outBranchCnt, outTakenCnt;

    int tests = 0;
    int fails = 0;

    branch_hazard_ctrl #(.CNT_W(16), .REG_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .inBranch     (inBranch),
        .inRsID       (inRsID),
        .inRtID       (inRtID),
        .inRegWriteEX (inRegWriteEX),
        .inMemReadEX  (inMemReadEX),
        .inRdEX       (inRdEX),
        .inRegWriteMEM(inRegWriteMEM),
        .inMemReadMEM (inMemReadMEM),
        .inRdMEM      (inRdMEM),
        .inRegWriteWB (inRegWriteWB),
        .inRdWB       (inRdWB),
        .inPCSrc      (inPCSrc),
        .outStall     (outStall),
        .outBubble    (outBubble),
        .outFlush     (outFlush),
        .outForwardA  (outForwardA),
        .outForwardB  (outForwardB),
        .outBranchCnt (outBranchCnt),
        .outTakenCnt  (outTakenCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pipe();
        inRegWriteEX  = 1'b0; inMemReadEX  = 1'b0; inRdEX  = 5'd0;
        inRegWriteMEM = 1'b0; inMemReadMEM = 1'b0; inRdMEM = 5'd0;
        inRegWriteWB  = 1'b0; inRdWB = 5'd0;
    endtask

    task automatic chk_ctrl(input string tag, input logic s, input logic f);
        chk({tag, "_stall"}, {31'd0, outStall},  {31'd0, s});
        chk({tag, "_bubble"}, {31'd0, outBubble}, {31'd0, s});
        chk({tag, "_flush"}, {31'd0, outFlush},  {31'd0, f});
    endtask

    task automatic chk_cnt(input string tag, input int b, input int t);
        chk({tag, "_bcnt"}, {16'd0, outBranchCnt}, b[31:0]);
        chk({tag, "_tcnt"}, {16'd0, outTakenCnt},  t[31:0]);
    endtask

    initial begin
        reset = 1'b1;
        inBranch = 1'b1; inRsID = 5'd8; inRtID = 5'd9; inPCSrc = 1'b1;
        clear_pipe();
        inRegWriteEX = 1'b1; inMemReadEX = 1'b1; inRdEX = 5'd8;
        #2;
        chk_ctrl("reset_hold", 1'b0, 1'b0);
        chk_cnt("reset_hold", 0, 0);
        tick();
        reset = 1'b0;
        #1;

        // Load in EX feeding BEQ $t0,$t1: two stall cycles.
        chk_ctrl("load_c1", 1'b1, 1'b0);
        tick();
        clear_pipe();
        inRegWriteMEM = 1'b1; inMemReadMEM = 1'b1; inRdMEM = 5'd8;
        #1;
        chk_ctrl("load_c2", 1'b1, 1'b0);
        tick();
        clear_pipe();
        inRegWriteWB = 1'b1; inRdWB = 5'd8;
        #1;
        chk_ctrl("load_res", 1'b0, 1'b1);
        chk("load_fwdA", {30'd0, outForwardA}, 32'd2);
        chk("load_fwdB", {30'd0, outForwardB}, 32'd0);
        tick();
        inBranch = 1'b0;
        #1;
        chk_ctrl("load_after", 1'b0, 1'b0);
        chk_cnt("load_after", 1, 1);

        // ALU write $t2 in EX, BNE $t3,$t2: one stall then forward from MEM.
        inBranch = 1'b1; inRsID = 5'd11; inRtID = 5'd10; inPCSrc = 1'b1;
        clear_pipe();
        inRegWriteEX = 1'b1; inRdEX = 5'd10;
        #1;
        chk_ctrl("alu_c1", 1'b1, 1'b0);
        tick();
        clear_pipe();
        inRegWriteMEM = 1'b1; inRdMEM = 5'd10; inPCSrc = 1'b0;
        #1;
        chk_ctrl("alu_res", 1'b0, 1'b0);
        chk("alu_fwdA", {30'd0, outForwardA}, 32'd0);
        chk("alu_fwdB", {30'd0, outForwardB}, 32'd1);
        tick();
        chk_cnt("alu_after", 2, 1);

        // Producers targeting $0 never stall or forward.
        inRsID = 5'd0; inRtID = 5'd0; inPCSrc = 1'b1;
        clear_pipe();
        inRegWriteEX = 1'b1; inMemReadEX = 1'b1; inRdEX = 5'd0;
        inRegWriteWB = 1'b1; inRdWB = 5'd0;
        #1;
        chk_ctrl("zero_res", 1'b0, 1'b1);
        chk("zero_fwdA", {30'd0, outForwardA}, 32'd0);
        chk("zero_fwdB", {30'd0, outForwardB}, 32'd0);
        tick();
        chk_cnt("zero_after", 3, 2);

        // MEM beats WB for the same register on both operands.
        inRsID = 5'd9; inRtID = 5'd9; inPCSrc = 1'b0;
        clear_pipe();
        inRegWriteMEM = 1'b1; inRdMEM = 5'd9;
        inRegWriteWB = 1'b1; inRdWB = 5'd9;
        #1;
        chk_ctrl("prio_res", 1'b0, 1'b0);
        chk("prio_fwdA", {30'd0, outForwardA}, 32'd1);
        chk("prio_fwdB", {30'd0, outForwardB}, 32'd1);
        tick();
        chk_cnt("prio_after", 4, 2);

        // Load in MEM: single stall, PCSrc ignored while stalling.
        inRsID = 5'd12; inRtID = 5'd13; inPCSrc = 1'b1;
        clear_pipe();
        inRegWriteMEM = 1'b1; inMemReadMEM = 1'b1; inRdMEM = 5'd12;
        #1;
        chk_ctrl("memld_c1", 1'b1, 1'b0);
        tick();
        clear_pipe();
        inRegWriteWB = 1'b1; inRdWB = 5'd13; inPCSrc = 1'b0;
        #1;
        chk_ctrl("memld_res", 1'b0, 1'b0);
        chk("memld_fwdB", {30'd0, outForwardB}, 32'd2);
        tick();
        chk_cnt("memld_after", 5, 2);

        // Reset during the STALL cycle.
        inRsID = 5'd8; inRtID = 5'd3; inPCSrc = 1'b1;
        clear_pipe();
        inRegWriteEX = 1'b1; inMemReadEX = 1'b1; inRdEX = 5'd8;
        tick();
        clear_pipe();
        inRegWriteWB = 1'b1; inRdWB = 5'd3;
        #1;
        chk_ctrl("rst_stall", 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk_ctrl("rst_mid", 1'b0, 1'b0);
        chk_cnt("rst_mid", 0, 0);
        chk("rst_fwdB", {30'd0, outForwardB}, 32'd2);
        tick();
        reset = 1'b0;
        #1;
        chk_ctrl("rst_res", 1'b0, 1'b1);
        tick();
        chk_cnt("rst_after", 1, 1);

        // Saturation: run taken branches up to all-ones, then one more.
        clear_pipe();
        inPCSrc = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        chk_cnt("sat_reach", 65535, 65535);
        tick();
        chk_cnt("sat_hold", 65535, 65535);
        inPCSrc = 1'b0;
        tick();
        chk_cnt("sat_nt", 65535, 65535);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
